// File: rtl/fetch_stage.sv
// WISC 16-bit instruction-fetch stage: owns the PC, drives a variable-latency
// instruction memory via rd/done, and feeds decode through an IF/ID register
// backed by a one-entry skid buffer. Handles redirects and HALT detection.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN,
        HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcp2_q, pcp2_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pcp2_q, skid_pcp2_d;
    logic [15:0] drain_addr_q, drain_addr_d;

    logic [15:0] pc_plus2;
    logic        if_free;
    logic        mem_is_halt;
    logic        skid_is_halt;

    assign pc_plus2     = pc_q + 16'd2;
    assign if_free      = !valid_q || !stall_in;
    assign mem_is_halt  = (imem_data[15:11] == 5'b00000);
    assign skid_is_halt = (skid_instr_q[15:11] == 5'b00000);

    // Memory request: active while fetching or draining an abandoned request
    always_comb begin
        imem_rd   = !rst && ((state_q == FETCH) || (state_q == DRAIN));
        imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    end

    assign instr_out    = instr_q;
    assign pc_plus2_out = pcp2_q;
    assign valid_out    = valid_q;
    assign halted       = halted_q;
    assign err          = err_q;

    // Next-state logic: redirect overrides everything except reset
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pcp2_d       = pcp2_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        err_d        = err_q;
        skid_instr_d = skid_instr_q;
        skid_pcp2_d  = skid_pcp2_q;
        drain_addr_d = drain_addr_q;

        if ((imem_done && !imem_rd) || (redirect_valid && redirect_pc[0])) begin
            err_d = 1'b1;
        end

        if (redirect_valid) begin
            pc_d     = {redirect_pc[15:1], 1'b0};
            valid_d  = 1'b0;
            instr_d  = NOP_INSTR;
            halted_d = 1'b0;
            // An in-flight request cannot be cancelled; hold its address
            // in DRAIN until the memory completes, then discard the data.
            if (state_q == DRAIN) begin
                state_d = imem_done ? FETCH : DRAIN;
            end else if ((state_q == FETCH) && !imem_done) begin
                drain_addr_d = pc_q;
                state_d      = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_done) begin
                        pc_d = pc_plus2;
                        if (if_free) begin
                            instr_d = imem_data;
                            pcp2_d  = pc_plus2;
                            valid_d = 1'b1;
                            if (mem_is_halt) begin
                                state_d  = HALTED;
                                halted_d = 1'b1;
                            end
                        end else begin
                            skid_instr_d = imem_data;
                            skid_pcp2_d  = pc_plus2;
                            state_d      = HOLD;
                        end
                    end else if (if_free) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        instr_d = skid_instr_q;
                        pcp2_d  = skid_pcp2_q;
                        valid_d = 1'b1;
                        if (skid_is_halt) begin
                            state_d  = HALTED;
                            halted_d = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_done) begin
                        state_d = FETCH;
                    end
                end
                HALTED: begin
                    if (if_free) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pcp2_q       <= '0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
            skid_instr_q <= '0;
            skid_pcp2_q  <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pcp2_q       <= pcp2_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            err_q        <= err_d;
            skid_instr_q <= skid_instr_d;
            skid_pcp2_q  <= skid_pcp2_d;
            drain_addr_q <= drain_addr_d;
        end
    end

endmodule
